jk_bank_arbiter: RTL and testbench

- Controller for a bank of WIDTH JK flip-flop cells, with the cells held internally as register q.
- Two requesters share the bank. Each submits a masked JK command (hold/clear/set/toggle) plus a repeat count.
- A round-robin arbiter grants one command at a time. A small FSM applies the command for len+1 consecutive clocks, then reports completion.
- Sits between software/sequencer command sources and the JK state bank.

---
 rtl/jk_bank_arbiter.sv | 144 ++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter feeding a bank of JK cells; each granted command is applied len+1 times.
// Optional abort/aborted ports are compiled in with JK_BANK_ARBITER_ABORT_EN.
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_mask,
    input  logic [CNT_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_mask,
    input  logic [CNT_W-1:0] req1_len,
`ifdef JK_BANK_ARBITER_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             grant_id,
    output logic             done
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] mask_r, mask_next;
    logic [1:0]       op_r, op_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic             done_next;
    logic             grant_next;
    logic             last_grant, last_next;
    logic             pick0, pick1;
    logic             abort_hit;
`ifdef JK_BANK_ARBITER_ABORT_EN
    logic             aborted_r, aborted_next;

    assign abort_hit = abort;
    assign aborted   = aborted_r;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] mask);
        logic [WIDTH-1:0] res;
        case (op)
            2'b01:   res = cur & ~mask;
            2'b10:   res = cur | mask;
            2'b11:   res = cur ^ mask;
            default: res = cur;
        endcase
        return res;
    endfunction

    // When both are valid, the requester that did not win last time gets the grant.
    assign pick0 = req0_valid && (!req1_valid || last_grant);
    assign pick1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = (state == IDLE) && !rst && pick0;
    assign req1_ready = (state == IDLE) && !rst && pick1;
    assign busy       = (state == EXEC);

    always_comb begin
        state_next   = state;
        q_next       = q;
        mask_next    = mask_r;
        op_next      = op_r;
        counter_next = counter;
        done_next    = 1'b0;
        grant_next   = grant_id;
        last_next    = last_grant;
`ifdef JK_BANK_ARBITER_ABORT_EN
        aborted_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_next      = req1_ready ? req1_op   : req0_op;
                    mask_next    = req1_ready ? req1_mask : req0_mask;
                    counter_next = req1_ready ? req1_len  : req0_len;
                    grant_next   = req1_ready;
                    last_next    = req1_ready;
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                if (abort_hit) begin
                    state_next   = IDLE;
                    counter_next = '0;
                    done_next    = 1'b1;
`ifdef JK_BANK_ARBITER_ABORT_EN
                    aborted_next = 1'b1;
`endif
                end else begin
                    q_next = apply_op(q, op_r, mask_r);
                    if (counter == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        counter_next = counter - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            mask_r     <= '0;
            op_r       <= 2'b00;
            counter    <= '0;
            done       <= 1'b0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
`ifdef JK_BANK_ARBITER_ABORT_EN
            aborted_r  <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            q          <= q_next;
            mask_r     <= mask_next;
            op_r       <= op_next;
            counter    <= counter_next;
            done       <= done_next;
            grant_id   <= grant_next;
            last_grant <= last_next;
`ifdef JK_BANK_ARBITER_ABORT_EN
            aborted_r  <= aborted_next;
`endif
        end
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: cycle reference model for handshakes, queue of expected completions.
module tb_jk_bank_arbiter;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_mask, req1_mask, q;
    logic [CNT_W-1:0] req0_len, req1_len;
    logic             busy, grant_id, done;
`ifdef JK_BANK_ARBITER_ABORT_EN
    logic             abort, aborted;
    bit               force_abort = 0;
`endif

    always #5 clk = ~clk;

    jk_bank_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_mask(req0_mask), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_mask(req1_mask), .req1_len(req1_len),
`ifdef JK_BANK_ARBITER_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .q(q), .busy(busy), .grant_id(grant_id), .done(done)
    );

    typedef struct {
        int         gid;
        logic [7:0] q;
        int         cyc;
        bit         ab;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // pending commands per requester
    bit         pv[2];
    logic [1:0] pop[2];
    logic [7:0] pmask[2];
    logic [3:0] plen[2];

    // reference model state
    logic [7:0] m_q, m_mask;
    logic [1:0] m_op;
    bit         m_busy, m_done, m_gid, m_last, m_ab;
    int         m_rem;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] jk(input logic [7:0] v, input logic [1:0] op, input logic [7:0] mk);
        logic [7:0] r = v;
        for (int i = 0; i < 8; i++) begin
            if (mk[i]) begin
                case (op)
                    2'b01:   r[i] = 1'b0;
                    2'b10:   r[i] = 1'b1;
                    2'b11:   r[i] = ~v[i];
                    default: r[i] = v[i];
                endcase
            end
        end
        return r;
    endfunction

    task automatic drive();
        req0_valid = pv[0]; req0_op = pop[0]; req0_mask = pmask[0]; req0_len = plen[0];
        req1_valid = pv[1]; req1_op = pop[1]; req1_mask = pmask[1]; req1_len = plen[1];
    endtask

    task automatic model_reset();
        m_q = '0; m_busy = 0; m_done = 0; m_gid = 0; m_last = 1; m_ab = 0; m_rem = 0;
        m_op = '0; m_mask = '0;
    endtask

    task automatic set_cmd(input int r, input logic [1:0] op, input logic [7:0] mk, input logic [3:0] len);
        pv[r] = 1; pop[r] = op; pmask[r] = mk; plen[r] = len;
    endtask

    // One clock: entered and left at a falling edge. mode 0 = directed, 1 = both always valid len 0, 2 = random.
    task automatic step(input int mode);
        int   win;
        bit   abort_now;
        exp_t e;
        logic [7:0] f;
        chk("q", q, m_q);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("grant_id", grant_id, m_gid);
`ifdef JK_BANK_ARBITER_ABORT_EN
        chk("aborted", aborted, m_ab);
`endif
        for (int r = 0; r < 2; r++) begin
            if (!pv[r]) begin
                if (mode == 1) begin
                    set_cmd(r, 2'($urandom_range(0, 3)), 8'($urandom), 4'd0);
                end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    set_cmd(r, 2'($urandom_range(0, 3)),
                            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                            ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3)));
                end
            end
        end
        drive();
        abort_now = 0;
`ifdef JK_BANK_ARBITER_ABORT_EN
        abort_now = force_abort || (mode == 2 && m_busy && $urandom_range(0, 11) == 0);
        abort = abort_now;
`endif
        #1;
        win = -1;
        if (!m_busy) begin
            if (pv[0] && pv[1]) win = m_last ? 0 : 1;
            else if (pv[0])     win = 0;
            else if (pv[1])     win = 1;
        end
        chk("req0_ready", req0_ready, win == 0);
        chk("req1_ready", req1_ready, win == 1);
        m_done = 0;
        m_ab   = 0;
        if (m_busy) begin
            if (abort_now) begin
                m_busy = 0; m_done = 1; m_ab = 1;
                e = sb.pop_back();
                e.q = m_q; e.cyc = cyc + 1; e.ab = 1;
                sb.push_back(e);
            end else begin
                m_q = jk(m_q, m_op, m_mask);
                if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                else m_rem--;
            end
        end else if (win >= 0) begin
            m_busy = 1; m_op = pop[win]; m_mask = pmask[win]; m_rem = int'(plen[win]);
            m_last = (win == 1); m_gid = (win == 1);
            f = m_q;
            for (int k = 0; k <= int'(plen[win]); k++) f = jk(f, m_op, m_mask);
            e.gid = win; e.q = f; e.cyc = cyc + int'(plen[win]) + 2; e.ab = 0;
            sb.push_back(e);
            pv[win] = 0;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || pv[0] || pv[1]) && n < 300) begin
            step(0);
            n++;
        end
        if (n >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: timeout still busy=%0d expected idle", m_busy);
        end
        step(0);
    endtask

    // Completion monitor: every done pulse retires the oldest expected command.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_q", q, e.q);
                chk("done_gid", grant_id, e.gid);
                chk("done_cycle", cyc, e.cyc);
`ifdef JK_BANK_ARBITER_ABORT_EN
                chk("done_aborted", aborted, e.ab);
`endif
            end
        end
    end

    initial begin
        logic [1:0] s_op;
        logic [7:0] s_mk;
        logic [3:0] s_len;
        pv[0] = 0; pv[1] = 0;
        for (int r = 0; r < 2; r++) begin pop[r] = '0; pmask[r] = '0; plen[r] = '0; end
        rst = 1;
        drive();
        req0_valid = 1;
`ifdef JK_BANK_ARBITER_ABORT_EN
        abort = 0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("ready_in_reset", req0_ready, 1'b0);
        chk("q_reset", q, 8'h00);
        @(negedge clk);
        rst = 0;

        // set 0x0F from req0, then three toggles of all cells from req1
        set_cmd(0, 2'b10, 8'h0F, 4'd0);
        wait_idle();
        chk("q_after_set", q, 8'h0F);
        set_cmd(1, 2'b11, 8'hFF, 4'd2);
        wait_idle();
        chk("q_after_toggle3", q, 8'hF0);

        // both requesters always valid: alternating single-cycle commands
        for (int i = 0; i < 12; i++) step(1);
        pv[0] = 0; pv[1] = 0;
        wait_idle();

        // clear through mask A5 on an all-ones bank, four applications
        set_cmd(0, 2'b10, 8'hFF, 4'd0);
        wait_idle();
        set_cmd(0, 2'b01, 8'hA5, 4'd3);
        wait_idle();
        chk("q_after_clear", q, 8'h5A);

        // even toggle count and the longest command restore the bank
        set_cmd(1, 2'b11, 8'h3C, 4'hF);
        wait_idle();
        chk("q_after_toggle16", q, 8'h5A);
        set_cmd(0, 2'b11, 8'h00, 4'd1);
        wait_idle();

        // reset in the middle of a long command; pending req0 must be regranted first
        s_op = 2'b11; s_mk = 8'hC3; s_len = 4'd7;
        set_cmd(0, s_op, s_mk, s_len);
        step(0);
        step(0);
        step(0);
        #2 rst = 1;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", req0_ready, 1'b0);
        model_reset();
        sb.delete();
        set_cmd(0, s_op, s_mk, s_len);
        set_cmd(1, 2'b10, 8'hFF, 4'd0);
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        wait_idle();

`ifdef JK_BANK_ARBITER_ABORT_EN
        set_cmd(0, 2'b01, 8'hFF, 4'd0);
        wait_idle();
        set_cmd(0, 2'b11, 8'h01, 4'd5);
        step(0);
        set_cmd(1, 2'b10, 8'h80, 4'd0);
        step(0);
        step(0);
        force_abort = 1;
        step(0);
        force_abort = 0;
        chk("q_after_abort", q, 8'h00);
        wait_idle();
`endif

        for (int i = 0; i < 1500; i++) step(2);
        pv[0] = 0; pv[1] = 0;
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
